// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: RV32 load/store opcodes,
// load size/sign encodings and the request-sequencing state type.
package mem_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } mem_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/half out of a memory word and extends it
// according to the load's size and signedness.
module load_align
    import mem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [1:0]      addr_lo_i,
    input  logic [XLEN-1:0] rdata_i,
    output logic [XLEN-1:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = rdata_i[7:0];
            2'd1:    byte_sel = rdata_i[15:8];
            2'd2:    byte_sel = rdata_i[23:16];
            default: byte_sel = rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        case (funct3_i)
            F3_LB:   data_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  data_o = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   data_o = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  data_o = {{(XLEN-16){1'b0}}, half_sel};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: sequences data-memory requests for loads/stores,
// stalls EX/MEM while a transaction is open and registers the MEM/WB bundle.
module mem_stage
    import mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        EXMEM_opcode_out,
    input  logic [2:0]        EXMEM_funct3_out,
    input  logic [XLEN-1:0]   EXMEM_data_addr_out,
    input  logic [3:0]        EXMEM_data_write_byte_out,
    input  logic              EXMEM_register_write_valid_out,
    input  logic [REG_AW-1:0] EXMEM_write_reg_out,
    input  logic [XLEN-1:0]   EXMEM_reg_write_data_out,
    input  logic [XLEN-1:0]   EXMEM_data_write_out,
    input  logic              EXMEM_pc_replace_out,
    input  logic              EXMEM_flag_out,
    output logic              dmem_req,
    input  logic              dmem_ready,
    output logic [XLEN-1:0]   dmem_addr,
    output logic [3:0]        dmem_byte_en,
    output logic [XLEN-1:0]   dmem_wdata,
    input  logic              dmem_rvalid,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              mem_stall,
    output logic              MEMWB_register_write_valid_out,
    output logic [REG_AW-1:0] MEMWB_write_reg_out,
    output logic [XLEN-1:0]   MEMWB_write_data_out,
    output logic              MEMWB_misaligned_out,
    output logic              MEMWB_pc_replace_out,
    output logic              MEMWB_flag_out
);

    mem_state_t state_q, state_d;

    logic is_load, is_store, mem_op, misaligned;
    logic store_done, load_done;
    logic [XLEN-1:0] load_data;

    logic              wb_valid_q, wb_valid_d;
    logic [REG_AW-1:0] wb_reg_q,   wb_reg_d;
    logic [XLEN-1:0]   wb_data_q,  wb_data_d;
    logic              wb_mis_q,   wb_mis_d;
    logic              wb_pcr_q,   wb_pcr_d;
    logic              wb_flag_q,  wb_flag_d;

    // A squashed load (write-valid low) is treated as a plain pass-through op.
    always_comb begin
        is_store   = |EXMEM_data_write_byte_out;
        is_load    = (EXMEM_opcode_out == OP_LOAD) && EXMEM_register_write_valid_out && !is_store;
        mem_op     = is_load || is_store;
        misaligned = 1'b0;
        case (EXMEM_funct3_out)
            F3_LH, F3_LHU: misaligned = is_load && EXMEM_data_addr_out[0];
            F3_LW:         misaligned = is_load && (|EXMEM_data_addr_out[1:0]);
            default:       misaligned = 1'b0;
        endcase
    end

    load_align #(.XLEN(XLEN)) u_align (
        .funct3_i  (EXMEM_funct3_out),
        .addr_lo_i (EXMEM_data_addr_out[1:0]),
        .rdata_i   (dmem_rdata),
        .data_o    (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (mem_op && !misaligned) begin
                    if (!dmem_ready) begin
                        state_d = REQ;
                    end else if (!is_store) begin
                        state_d = RESP;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    state_d = is_store ? IDLE : RESP;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        dmem_req     = ((state_q == IDLE) && mem_op && !misaligned) || (state_q == REQ);
        dmem_addr    = dmem_req ? {EXMEM_data_addr_out[XLEN-1:2], 2'b00} : '0;
        dmem_byte_en = dmem_req ? EXMEM_data_write_byte_out : 4'b0000;
        dmem_wdata   = dmem_req ? EXMEM_data_write_out : '0;

        store_done = dmem_req && dmem_ready && is_store;
        load_done  = (state_q == RESP) && dmem_rvalid;
        mem_stall  = (dmem_req && !store_done) || ((state_q == RESP) && !dmem_rvalid);

        // Stalled edges write a bubble; register/data fields simply hold.
        wb_valid_d = 1'b0;
        wb_mis_d   = 1'b0;
        wb_pcr_d   = 1'b0;
        wb_flag_d  = 1'b0;
        wb_reg_d   = wb_reg_q;
        wb_data_d  = wb_data_q;
        if (!mem_stall) begin
            wb_reg_d  = EXMEM_write_reg_out;
            wb_pcr_d  = EXMEM_pc_replace_out;
            wb_flag_d = EXMEM_flag_out;
            wb_data_d = EXMEM_reg_write_data_out;
            if (load_done) begin
                wb_valid_d = 1'b1;
                wb_data_d  = load_data;
            end else if (store_done) begin
                wb_valid_d = 1'b0;
            end else if (misaligned) begin
                wb_mis_d   = 1'b1;
            end else begin
                wb_valid_d = EXMEM_register_write_valid_out;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_valid_q <= 1'b0;
            wb_reg_q   <= '0;
            wb_data_q  <= '0;
            wb_mis_q   <= 1'b0;
            wb_pcr_q   <= 1'b0;
            wb_flag_q  <= 1'b0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_reg_q   <= wb_reg_d;
            wb_data_q  <= wb_data_d;
            wb_mis_q   <= wb_mis_d;
            wb_pcr_q   <= wb_pcr_d;
            wb_flag_q  <= wb_flag_d;
        end
    end

    assign MEMWB_register_write_valid_out = wb_valid_q;
    assign MEMWB_write_reg_out            = wb_reg_q;
    assign MEMWB_write_data_out           = wb_data_q;
    assign MEMWB_misaligned_out           = wb_mis_q;
    assign MEMWB_pc_replace_out           = wb_pcr_q;
    assign MEMWB_flag_out                 = wb_flag_q;

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver issues EX/MEM ops and queues the
// expected write-back bundle and memory request; a memory model responds.
module tb_mem_stage;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   daddr;
    logic [3:0]        wbyte;
    logic              rwv;
    logic [REG_AW-1:0] wreg;
    logic [XLEN-1:0]   alu;
    logic [XLEN-1:0]   wdata;
    logic              pcr;
    logic              flg;
    logic              dmem_req;
    logic              dmem_ready = 1'b0;
    logic [XLEN-1:0]   dmem_addr;
    logic [3:0]        dmem_byte_en;
    logic [XLEN-1:0]   dmem_wdata;
    logic              dmem_rvalid = 1'b0;
    logic [XLEN-1:0]   dmem_rdata = '0;
    logic              mem_stall;
    logic              wb_v;
    logic [REG_AW-1:0] wb_rd;
    logic [XLEN-1:0]   wb_d;
    logic              wb_mis;
    logic              wb_pcr;
    logic              wb_flg;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(XLEN), .REG_AW(REG_AW)) dut (
        .clk                            (clk),
        .rst_n                          (rst_n),
        .EXMEM_opcode_out               (opcode),
        .EXMEM_funct3_out               (funct3),
        .EXMEM_data_addr_out            (daddr),
        .EXMEM_data_write_byte_out      (wbyte),
        .EXMEM_register_write_valid_out (rwv),
        .EXMEM_write_reg_out            (wreg),
        .EXMEM_reg_write_data_out       (alu),
        .EXMEM_data_write_out           (wdata),
        .EXMEM_pc_replace_out           (pcr),
        .EXMEM_flag_out                 (flg),
        .dmem_req                       (dmem_req),
        .dmem_ready                     (dmem_ready),
        .dmem_addr                      (dmem_addr),
        .dmem_byte_en                   (dmem_byte_en),
        .dmem_wdata                     (dmem_wdata),
        .dmem_rvalid                    (dmem_rvalid),
        .dmem_rdata                     (dmem_rdata),
        .mem_stall                      (mem_stall),
        .MEMWB_register_write_valid_out (wb_v),
        .MEMWB_write_reg_out            (wb_rd),
        .MEMWB_write_data_out           (wb_d),
        .MEMWB_misaligned_out           (wb_mis),
        .MEMWB_pc_replace_out           (wb_pcr),
        .MEMWB_flag_out                 (wb_flg)
    );

    typedef struct {
        logic        v;
        logic [4:0]  rd;
        logic [31:0] d;
        logic        mis;
        logic        pcr;
        logic        flg;
        logic        chkd;
    } wb_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
    } rq_t;

    wb_t         exp_q[$];
    rq_t         req_q[$];
    logic [31:0] ref_mem[128];
    logic [31:0] dut_mem[128];

    int total = 0;
    int bad   = 0;
    bit issue_active = 0;
    bit mon_en = 0;
    bit stray_en = 0;
    int rdy_cnt = 0;
    int rv_wait = 0;
    int rv_cnt = 0;
    bit rd_pending = 0;
    logic [31:0] rd_word = '0;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU_R = 7'b0110011;
    localparam logic [6:0] ALU_I = 7'b0010011;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, req, $time);
        end
    endtask

    // Reference load result, straight from the size/sign rules.
    function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
        int unsigned b, h;
        b = (w >> (8 * int'(a))) & 32'hFF;
        h = (w >> (16 * (int'(a) / 2))) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    task automatic set_nop();
        opcode = ALU_R; funct3 = 3'd0; daddr = '0; wbyte = 4'h0; rwv = 1'b0;
        wreg = '0; alu = '0; wdata = '0; pcr = 1'b0; flg = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        set_nop();
        issue_active = 0;
    endtask

    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [3:0] be, input logic wv, input logic [4:0] rd,
                         input logic [31:0] ad, input logic [31:0] wd, input logic p,
                         input logic f, input int w, input int r);
        wb_t e;
        rq_t q;
        bit ld, st, mis, done;
        int exp_req, exp_stall, n_req, n_stall;
        st  = (be != 4'h0);
        ld  = (op == LOAD) && wv && !st;
        mis = ld && ((((f3 == 3'd1) || (f3 == 3'd5)) && addr[0]) || ((f3 == 3'd2) && (addr[1:0] != 2'b00)));
        e.v = wv; e.rd = rd; e.d = ad; e.mis = mis; e.pcr = p; e.flg = f; e.chkd = wv;
        if (st) begin
            e.v = 1'b0; e.chkd = 1'b0;
            for (int k = 0; k < 4; k++)
                if (be[k]) ref_mem[addr[8:2]][8*k +: 8] = wd[8*k +: 8];
        end else if (mis) begin
            e.v = 1'b0; e.chkd = 1'b0;
        end else if (ld) begin
            e.d = load_fmt(f3, addr[1:0], ref_mem[addr[8:2]]);
        end
        exp_req   = (st || (ld && !mis)) ? w + 1 : 0;
        exp_stall = st ? w : ((ld && !mis) ? w + 1 + r : 0);
        if (exp_req > 0) begin
            q.addr = addr & 32'hFFFF_FFFC; q.be = be; q.wd = wd;
            req_q.push_back(q);
        end
        exp_q.push_back(e);

        @(negedge clk);
        opcode = op; funct3 = f3; daddr = addr; wbyte = be; rwv = wv;
        wreg = rd; alu = ad; wdata = wd; pcr = p; flg = f;
        rdy_cnt = w; rv_wait = r; issue_active = 1;
        n_req = 0; n_stall = 0; done = 0;
        while (!done) begin
            #2;
            if (dmem_req === 1'b1) n_req++;
            if (mem_stall === 1'b0) begin
                done = 1;
            end else begin
                n_stall++;
                if (n_stall > 40) begin
                    chk("issue_timeout", 32'(n_stall), 32'(exp_stall));
                    done = 1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        chk("req_cycles", 32'(n_req), 32'(exp_req));
        chk("stall_cycles", 32'(n_stall), 32'(exp_stall));
    endtask

    // Data-memory model: ready after rdy_cnt waits, rvalid rv_wait cycles after acceptance.
    initial begin
        rq_t q;
        logic [6:0] idx;
        forever begin
            @(negedge clk);
            #1;
            dmem_ready = 1'b0;
            if (dmem_req === 1'b1) begin
                if (rdy_cnt == 0) dmem_ready = 1'b1;
                else rdy_cnt--;
            end
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (rd_pending) begin
                if (rv_cnt == 0) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata  = rd_word;
                    rd_pending  = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (stray_en && ($urandom_range(0, 7) == 0)) begin
                dmem_rvalid = 1'b1;
            end
            #1;
            if ((dmem_req === 1'b1) && dmem_ready) begin
                if (req_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL req_unexpected actual=0x%08h required=none t=%0t", dmem_addr, $time);
                end else begin
                    q = req_q.pop_front();
                    chk("req_addr", dmem_addr, q.addr);
                    chk("req_be", 32'(dmem_byte_en), 32'(q.be));
                    if (q.be != 4'h0) chk("req_wdata", dmem_wdata, q.wd);
                end
                idx = dmem_addr[8:2];
                if (dmem_byte_en == 4'h0) begin
                    rd_word = dut_mem[idx]; rd_pending = 1; rv_cnt = rv_wait;
                end else begin
                    for (int k = 0; k < 4; k++)
                        if (dmem_byte_en[k]) dut_mem[idx][8*k +: 8] = dmem_wdata[8*k +: 8];
                end
            end
        end
    end

    // Monitor: an op retires at an edge where mem_stall was low; stalled edges must leave a bubble.
    initial begin
        wb_t e;
        bit retire, bubble;
        retire = 0; bubble = 0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && retire) begin
                if (exp_q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL wb_unexpected actual=0x%08h required=none t=%0t", wb_d, $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_valid", 32'(wb_v), 32'(e.v));
                    chk("wb_misaligned", 32'(wb_mis), 32'(e.mis));
                    chk("wb_pc_replace", 32'(wb_pcr), 32'(e.pcr));
                    chk("wb_flag", 32'(wb_flg), 32'(e.flg));
                    if (e.chkd) begin
                        chk("wb_reg", 32'(wb_rd), 32'(e.rd));
                        chk("wb_data", wb_d, e.d);
                    end
                end
            end else if (mon_en && bubble) begin
                chk("bubble_valid", 32'(wb_v), 32'd0);
                chk("bubble_misaligned", 32'(wb_mis), 32'd0);
            end
            retire = mon_en && rst_n && issue_active && (mem_stall === 1'b0);
            bubble = mon_en && rst_n && issue_active && (mem_stall === 1'b1);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int kind;
        logic [2:0] f3s[6];
        f3s[0] = 3'd0; f3s[1] = 3'd1; f3s[2] = 3'd2; f3s[3] = 3'd4; f3s[4] = 3'd5; f3s[5] = 3'd3;
        for (int i = 0; i < 128; i++) begin
            ref_mem[i] = $urandom;
            dut_mem[i] = ref_mem[i];
        end
        set_nop();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valid", 32'(wb_v), 32'd0);
        chk("rst_reg", 32'(wb_rd), 32'd0);
        chk("rst_data", wb_d, 32'd0);
        chk("rst_misaligned", 32'(wb_mis), 32'd0);
        chk("rst_pc_replace", 32'(wb_pcr), 32'd0);
        chk("rst_flag", 32'(wb_flg), 32'd0);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_stall", 32'(mem_stall), 32'd0);
        rst_n = 1'b1;
        mon_en = 1;

        issue(ALU_R, 3'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'h1234, 32'h0, 1'b0, 1'b0, 0, 0);
        ref_mem[7'h40] = 32'h80FF_0000; dut_mem[7'h40] = 32'h80FF_0000;
        issue(LOAD, 3'd0, 32'h103, 4'h0, 1'b1, 5'd6, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0);
        issue(STORE, 3'd2, 32'h70, 4'hF, 1'b0, 5'd0, 32'h70, 32'h0C00_0000, 1'b0, 1'b1, 3, 0);
        idle();
        ref_mem[7'h1C] = 32'hBEEF_1234; dut_mem[7'h1C] = 32'hBEEF_1234;
        issue(LOAD, 3'd5, 32'h72, 4'h0, 1'b1, 5'd9, 32'h0, 32'h0, 1'b0, 1'b1, 0, 1);
        issue(LOAD, 3'd2, 32'h72, 4'h0, 1'b1, 5'd10, 32'h0, 32'h0, 1'b1, 1'b1, 0, 0);
        issue(LOAD, 3'd0, 32'h44, 4'h0, 1'b0, 5'd11, 32'hDEAD, 32'h0, 1'b0, 1'b0, 0, 0);
        issue(STORE, 3'd0, 32'h101, 4'h2, 1'b0, 5'd0, 32'h0, 32'h0000_5A00, 1'b0, 1'b0, 0, 0);
        issue(LOAD, 3'd4, 32'h101, 4'h0, 1'b1, 5'd12, 32'h0, 32'h0, 1'b0, 1'b0, 2, 2);

        // Reset while a load waits for its response; the late rvalid must be ignored.
        idle();
        #3;
        mon_en = 0;
        stray_en = 0;
        req_q.push_back('{addr: 32'h40, be: 4'h0, wd: 32'h0});
        @(negedge clk);
        opcode = LOAD; funct3 = 3'd2; daddr = 32'h40; rwv = 1'b1; wreg = 5'd7;
        rdy_cnt = 0; rv_wait = 3;
        @(negedge clk);
        #2;
        chk("resp_stall", 32'(mem_stall), 32'd1);
        rst_n = 1'b0;
        set_nop();
        @(negedge clk);
        #2;
        chk("mid_rst_req", 32'(dmem_req), 32'd0);
        chk("mid_rst_stall", 32'(mem_stall), 32'd0);
        chk("mid_rst_valid", 32'(wb_v), 32'd0);
        chk("mid_rst_data", wb_d, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("late_rvalid_seen", 32'(dmem_rvalid), 32'd1);
        chk("late_rvalid_stall", 32'(mem_stall), 32'd0);
        chk("late_rvalid_req", 32'(dmem_req), 32'd0);
        @(negedge clk);
        #2;
        chk("late_rvalid_valid", 32'(wb_v), 32'd0);
        chk("late_rvalid_data", wb_d, 32'd0);
        mon_en = 1;
        stray_en = 1;

        for (int n = 0; n < 300; n++) begin
            kind = $urandom_range(0, 9);
            if (kind <= 2) begin
                issue(($urandom_range(0, 1) == 0) ? ALU_R : ALU_I, 3'($urandom), $urandom,
                      4'h0, 1'($urandom), 5'($urandom), $urandom, $urandom,
                      1'($urandom), 1'($urandom), 0, 0);
            end else if (kind <= 5) begin
                issue(LOAD, f3s[$urandom_range(0, 5)], 32'($urandom_range(0, 511)), 4'h0, 1'b1,
                      5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (kind <= 7) begin
                issue(STORE, 3'($urandom), 32'($urandom_range(0, 511)), 4'($urandom_range(1, 15)),
                      1'b0, 5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom),
                      $urandom_range(0, 3), 0);
            end else if (kind == 8) begin
                issue(LOAD, 3'($urandom), 32'($urandom_range(0, 511)), 4'h0, 1'b0,
                      5'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom), 0, 0);
            end else begin
                idle();
            end
        end

        idle();
        repeat (3) @(negedge clk);
        #3;
        chk("wb_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("req_queue_drained", 32'(req_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage sitting directly downstream of the EX/MEM pipeline register. It consumes that register's outputs.
- Issues loads and stores to the data memory over a valid/ready request plus response-valid interface.
- Aligns and sign/zero-extends load data.
- Produces the registered MEM/WB bundle for write-back.
- Stalls upstream via mem_stall while a memory transaction is outstanding.

Parameters:
- XLEN, 32, data and address width.
- REG_AW, 5, register index width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- EXMEM_opcode_out  in  7  instruction opcode
- EXMEM_funct3_out  in  3  load/store size and sign
- EXMEM_data_addr_out  in  XLEN  effective address
- EXMEM_data_write_byte_out  in  4  store byte enables, already lane-aligned; 0 = no store
- EXMEM_register_write_valid_out  in  1  destination write enable
- EXMEM_write_reg_out  in  REG_AW  destination register
- EXMEM_reg_write_data_out  in  XLEN  ALU result
- EXMEM_data_write_out  in  XLEN  store data, already lane-aligned
- EXMEM_pc_replace_out  in  1  redirect marker, passed through
- EXMEM_flag_out  in  1  flag, passed through
- dmem_req  out  1  request valid
- dmem_ready  in  1  request accepted this cycle
- dmem_addr  out  XLEN  word address; bits [1:0] forced to 0
- dmem_byte_en  out  4  byte enables; 0 = read
- dmem_wdata  out  XLEN  write data
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  XLEN  read word
- mem_stall  out  1  upstream must hold EX/MEM contents
- MEMWB_register_write_valid_out  out  1  write-back enable
- MEMWB_write_reg_out  out  REG_AW  write-back register
- MEMWB_write_data_out  out  XLEN  load result or ALU result
- MEMWB_misaligned_out  out  1  misaligned load detected
- MEMWB_pc_replace_out  out  1  passed through
- MEMWB_flag_out  out  1  passed through

Behaviour:
- Reset is synchronous, active-low, on posedge clk. After reset: state IDLE and every MEMWB_* output is 0.
- Classification:
  - is_load: opcode = 7'b0000011 and register_write_valid = 1.
  - is_store: data_write_byte != 0.
  - mem_op: is_load or is_store.
  - A load with register_write_valid = 0 (squashed) is not a load and issues no request.
- Misaligned load:
  - Condition: funct3 LH/LHU with addr[0] = 1, or LW with addr[1:0] != 0.
  - Effect: no request. One cycle later MEMWB_misaligned_out = 1 and MEMWB_register_write_valid_out = 0.
  - Misaligned stores are not detected; their byte enables are used as given.
- States: IDLE, REQ, RESP.
- dmem_req = (IDLE and mem_op and not misaligned) or REQ. dmem_addr, dmem_byte_en and dmem_wdata are driven from the EX/MEM inputs whenever dmem_req = 1.
- IDLE transitions:
  - Not mem_op: the bundle registers at the next edge; latency 1 and no stall.
  - Request issued and dmem_ready = 1: a store completes at this edge with MEMWB write-valid 0; a load goes to RESP.
  - Request issued and dmem_ready = 0: go to REQ.
- REQ: hold dmem_req until dmem_ready. Then a store completes and a load goes to RESP.
- RESP:
  - On dmem_rvalid, the formatted load data registers into MEMWB_write_data_out with write-valid 1, and the state returns to IDLE.
  - dmem_rvalid outside RESP is ignored.
- mem_stall = (dmem_req and not (store and dmem_ready)) or (RESP and not dmem_rvalid). It is combinational and drops in the completing cycle so upstream advances at the same edge.
- While stalled, each edge writes a bubble: MEMWB write-valid 0 and misaligned 0.
- Load format. The byte/half is selected by addr[1:0] / addr[1]:
  - LB: sign-extend byte.
  - LBU: zero-extend byte.
  - LH: sign-extend half.
  - LHU: zero-extend half.
  - LW: full word.
  - Other funct3: full word.
- Minimum latency:
  - Store: 1 cycle.
  - Load: 2 cycles (ready in the issue cycle, rvalid the next cycle).
- Reset mid-transaction: the state returns to IDLE and dmem_req drops after the reset edge. A late dmem_rvalid is ignored.
- pc_replace and flag register alongside the bundle at the completing edge.

Decomposition:
- Package mem_pkg: opcode constants (OP_LOAD, OP_STORE), funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU), state enum mem_state_t.
- Sub-module load_align: combinational; inputs funct3, addr[1:0], rdata; output formatted word.

Test Plan:
1. ALU op: opcode 0110011, write-valid 1, reg 5, data 0x1234 → after 1 edge MEMWB valid 1, reg 5, data 0x1234; mem_stall never 1.
2. LB at addr 0x103; ready same cycle; rvalid next cycle with rdata 0x80FF_0000 → data 0xFFFF_FF80, valid 1; mem_stall high exactly 1 cycle.
3. SW to 0x70, byte_en 4'b1111, wdata 0x0C00_0000; ready delayed 3 cycles → dmem_req held 4 cycles with dmem_addr 0x70; stall 3 cycles; MEMWB valid 0.
4. LHU at addr 0x72, rdata 0xBEEF_1234 → data 0x0000_BEEF. LW at 0x72 → no dmem_req; misaligned 1; valid 0.
5. Squashed load (write-valid 0, byte_en 0) → no request, no stall, MEMWB valid 0.
6. rst_n low in RESP, then rvalid arrives → state IDLE; MEMWB outputs stay 0; the stray rvalid is ignored.
